// File: rtl/tcb_arb_pkg.sv
// Shared TCB field widths, request/response typedefs and a small wrap helper
// used by the arbiter and its priority search.
package tcb_arb_pkg;

    localparam int TCB_AW = 32;
    localparam int TCB_DW = 32;
    localparam int TCB_BW = TCB_DW / 8;

    // Manager-side request fields, gathered so interface arrays become indexable
    typedef struct packed {
        logic              wen;
        logic [TCB_BW-1:0] ben;
        logic [TCB_AW-1:0] adr;
        logic [TCB_DW-1:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [TCB_DW-1:0] rdt;
    } tcb_rsp_t;

    // Slot k positions after base, wrapping at n
    function automatic int unsigned rr_slot(int unsigned base, int unsigned k, int unsigned n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/tcb_if.sv
// TCB point-to-point interface: vld/rdy handshake, response one cycle later.
interface tcb_if;
    import tcb_arb_pkg::*;

    logic              vld;
    logic              wen;
    logic [TCB_BW-1:0] ben;
    logic [TCB_AW-1:0] adr;
    logic [TCB_DW-1:0] wdt;
    logic [TCB_DW-1:0] rdt;
    logic              rdy;

    modport man (output vld, wen, ben, adr, wdt, input  rdt, rdy);
    modport sub (input  vld, wen, ben, adr, wdt, output rdt, rdy);

endinterface

// File: rtl/tcb_arb_rr.sv
// Grant search: request vector + start pointer -> one-hot grant and its index.
// Purely combinational. TCB_ARB_RR_EN selects round-robin search starting at
// ptr; otherwise lowest index wins and ptr is ignored.
module tcb_arb_rr
    import tcb_arb_pkg::*;
#(
    parameter int MN = 2,
    parameter int SW = 1
) (
    input  logic [MN-1:0] req,
    input  logic [SW-1:0] ptr,
    output logic [MN-1:0] gnt,
    output logic [SW-1:0] idx
);

    logic found;

`ifdef TCB_ARB_RR_EN
    // First requester found walking upward from ptr, wrapping past MN-1
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < MN; k++) begin
            if (!found && req[rr_slot(int'(ptr), k, MN)]) begin
                found = 1'b1;
                gnt[rr_slot(int'(ptr), k, MN)] = 1'b1;
                idx   = SW'(rr_slot(int'(ptr), k, MN));
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest-indexed requester wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < MN; k++) begin
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = SW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/tcb_arb.sv
// N-to-1 TCB arbiter: MN managers share one subordinate port.
// Request path and rdy are combinational; rdt is routed back one cycle after
// the handshake through the rsp_sel register. A stalled grant is locked until
// its transfer completes. Macro TCB_ARB_RR_EN enables round-robin priority
// (ptr register); without it the lowest index wins.
// AW/DW must match the widths in tcb_arb_pkg, which also size tcb_if.
module tcb_arb
    import tcb_arb_pkg::*;
#(
    parameter int AW = TCB_AW,
    parameter int DW = TCB_DW,
    parameter int MN = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    tcb_if.sub    s [MN],
    tcb_if.man    m
);

    localparam int SW = (MN > 1) ? $clog2(MN) : 1;

    tcb_req_t      req [MN];
    logic [MN-1:0] req_vld;
    logic [MN-1:0] rdy_vec;
    logic [MN-1:0] arb_gnt;
    logic [SW-1:0] arb_idx;
    logic [MN-1:0] gnt;
    logic [SW-1:0] gnt_idx;
    logic [SW-1:0] ptr;
    logic          lock_q;
    logic [SW-1:0] lock_idx;
    logic [SW-1:0] rsp_sel;
    logic          use_lock;
    logic          req_any;
    logic          m_vld;
    logic          xfer;
    logic          stall;

    for (genvar i = 0; i < MN; i++) begin : g_s
        assign req_vld[i] = s[i].vld;
        assign req[i]     = '{wen: s[i].wen, ben: s[i].ben, adr: s[i].adr, wdt: s[i].wdt};
        assign s[i].rdy   = rdy_vec[i];
        assign s[i].rdt   = (rsp_sel == SW'(i)) ? m.rdt[DW-1:0] : 'x;
    end

    tcb_arb_rr #(.MN(MN), .SW(SW)) u_rr (
        .req (req_vld),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // A locked grant only sticks while its owner still requests
    assign use_lock = lock_q & req_vld[lock_idx];
    assign gnt      = use_lock ? (MN'(1) << lock_idx) : arb_gnt;
    assign gnt_idx  = use_lock ? lock_idx : arb_idx;
    assign req_any  = |req_vld;

    assign m_vld = rst_n & req_any;
    assign xfer  = m_vld & m.rdy;
    assign stall = m_vld & ~m.rdy;

    assign m.vld = m_vld;
    assign m.wen = req_any ? req[gnt_idx].wen            : 'x;
    assign m.ben = req_any ? req[gnt_idx].ben[DW/8-1:0]  : 'x;
    assign m.adr = req_any ? req[gnt_idx].adr[AW-1:0]    : 'x;
    assign m.wdt = req_any ? req[gnt_idx].wdt[DW-1:0]    : 'x;

    assign rdy_vec = (rst_n && m.rdy) ? gnt : '0;

    // Grant lock across stalls, and response steering for the next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q   <= 1'b0;
            lock_idx <= '0;
            rsp_sel  <= '0;
        end else begin
            lock_q <= stall;
            if (stall) lock_idx <= gnt_idx;
            if (xfer)  rsp_sel  <= gnt_idx;
        end
    end

`ifdef TCB_ARB_RR_EN
    // Round-robin pointer moves just past the manager that was served
    always_ff @(posedge clk) begin
        if (!rst_n)    ptr <= '0;
        else if (xfer) ptr <= SW'(rr_slot(int'(gnt_idx), 1, MN));
    end
`else
    assign ptr = '0;
`endif

endmodule

// File: tb/tb_tcb_arb.sv
// Directed bench for tcb_arb with MN=2 and a 1-cycle SRAM subordinate.
// Expected grant order follows TCB_ARB_RR_EN as compiled.
module tb_tcb_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  vld;
    logic [31:0] adr_r [2];
    logic        mrdy;
    logic [1:0]  rdy_v;
    logic [31:0] rdt_v [2];
    logic [31:0] m_rdt;
    logic [31:0] mem [0:255];
    int          n_run  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    tcb_if s_if [2] ();
    tcb_if m_if ();

    tcb_arb #(.AW(32), .DW(32), .MN(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s_if),
        .m     (m_if)
    );

    for (genvar g = 0; g < 2; g++) begin : g_drv
        assign s_if[g].vld = vld[g];
        assign s_if[g].wen = 1'b0;
        assign s_if[g].ben = 4'hF;
        assign s_if[g].adr = adr_r[g];
        assign s_if[g].wdt = ~adr_r[g];
        assign rdy_v[g]    = s_if[g].rdy;
        assign rdt_v[g]    = s_if[g].rdt;
    end

    // 1-cycle SRAM: data appears the cycle after the handshake
    always @(posedge clk)
        if (m_if.vld && m_if.rdy) m_rdt <= mem[m_if.adr[7:0]];
    assign m_if.rdt = m_rdt;
    assign m_if.rdy = mrdy;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cont_data(int p);
        return (p == 0) ? 32'hA0A0_0020 : 32'hB1B1_0024;
    endfunction

    // Protocol monitors: single rdy, held request fields during a stall
    logic        prev_stall = 1'b0;
    logic [68:0] prev_f;
    always @(negedge clk) begin
        chk("rdy_onehot", 96'($countones(rdy_v) <= 1), 96'd1);
        if (prev_stall && rst_n && m_if.vld)
            chk("m_stable", 96'({m_if.wen, m_if.ben, m_if.adr, m_if.wdt}), 96'(prev_f));
        prev_stall <= rst_n && m_if.vld && !m_if.rdy;
        prev_f     <= {m_if.wen, m_if.ben, m_if.adr, m_if.wdt};
    end

    int exp_g [4];

    initial begin
        mem[8'h10] = 32'hCAFE_0001;
        mem[8'h20] = 32'hA0A0_0020;
        mem[8'h24] = 32'hB1B1_0024;
        mem[8'h30] = 32'hC3C3_0030;
`ifdef TCB_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif

        // 1: reset with both managers requesting
        rst_n = 1'b0; vld = 2'b11; adr_r[0] = 32'h20; adr_r[1] = 32'h24; mrdy = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_mvld", 96'(m_if.vld), 96'd0);
        chk("rst_rdy", 96'(rdy_v), 96'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_first_gnt", 96'(rdy_v), 96'b01);
        chk("rst_first_adr", 96'(m_if.adr), 96'h20);
        tick();

        // 2: solo read from s[1]
        vld = 2'b10; adr_r[1] = 32'h10;
        @(negedge clk);
        chk("solo_rdy", 96'(rdy_v), 96'b10);
        chk("solo_adr", 96'(m_if.adr), 96'h10);
        tick();
        vld = 2'b00;
        @(negedge clk);
        chk("solo_rdt", 96'(rdt_v[1]), 96'hCAFE_0001);
        chk("solo_idle_rdy", 96'(rdy_v), 96'd0);
        tick();

        // 3/4: contention for four cycles, then s[0] drops
        vld = 2'b11; adr_r[0] = 32'h20; adr_r[1] = 32'h24;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("cont_gnt", 96'(rdy_v), 96'(2'b01 << exp_g[c]));
            if (c > 0) chk("cont_rdt", 96'(rdt_v[exp_g[c-1]]), 96'(cont_data(exp_g[c-1])));
            tick();
        end
        vld = 2'b10;
        @(negedge clk);
        chk("cont_s1_gnt", 96'(rdy_v), 96'b10);
        chk("cont_last_rdt", 96'(rdt_v[exp_g[3]]), 96'(cont_data(exp_g[3])));
        tick();
        vld = 2'b00;
        @(negedge clk);
        chk("cont_s1_rdt", 96'(rdt_v[1]), 96'hB1B1_0024);
        tick();

        // 5: s[1] stalls three cycles, s[0] arrives mid-stall
        vld = 2'b10; adr_r[1] = 32'h30; mrdy = 1'b0;
        @(negedge clk);
        chk("stall_mvld", 96'(m_if.vld), 96'd1);
        chk("stall_adr0", 96'(m_if.adr), 96'h30);
        chk("stall_rdy0", 96'(rdy_v), 96'd0);
        tick();
        vld = 2'b11;
        @(negedge clk);
        chk("stall_adr1", 96'(m_if.adr), 96'h30);
        tick();
        @(negedge clk);
        chk("stall_adr2", 96'(m_if.adr), 96'h30);
        tick();
        mrdy = 1'b1;
        @(negedge clk);
        chk("stall_rel_gnt", 96'(rdy_v), 96'b10);
        tick();
        vld = 2'b01;
        @(negedge clk);
        chk("stall_next_gnt", 96'(rdy_v), 96'b01);
        chk("stall_rdt1", 96'(rdt_v[1]), 96'hC3C3_0030);
        tick();
        vld = 2'b00;
        @(negedge clk);
        chk("stall_rdt0", 96'(rdt_v[0]), 96'hA0A0_0020);
        tick();

        // 6: reset while the lock is held
        vld = 2'b10; adr_r[1] = 32'h30; mrdy = 1'b0;
        @(negedge clk);
        chk("rst2_pre_adr", 96'(m_if.adr), 96'h30);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_mvld", 96'(m_if.vld), 96'd0);
        chk("rst2_rdy", 96'(rdy_v), 96'd0);
        tick();
        rst_n = 1'b1; vld = 2'b11; mrdy = 1'b1;
        @(negedge clk);
        chk("rst2_gnt", 96'(rdy_v), 96'b01);
        chk("rst2_adr", 96'(m_if.adr), 96'h20);
        tick();
        vld = 2'b00;
        @(negedge clk);
        chk("rst2_rdt0", 96'(rdt_v[0]), 96'hA0A0_0020);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
